// File: rtl/mu0_pkg.sv
// rtl/mu0_pkg.sv - shared constants and loader state encoding for the mu0 boot loader
package mu0_pkg;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 16;
    localparam int MAX_WORDS = 4096;

    // Word counter must hold MAX_WORDS itself, so it is one bit wider than an address.
    localparam int CNT_W = ADDR_W + 1;

    // Largest legal length field, sized to the 16-bit length word for clean comparison.
    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        LEN_H  = 3'd0,
        LEN_L  = 3'd1,
        DATA_H = 3'd2,
        DATA_L = 3'd3,
        CHK    = 3'd4,
        RUN    = 3'd5,
        ERR    = 3'd6
    } ldr_state_e;

endpackage

// File: rtl/mu0_bus_mux.sv
// rtl/mu0_bus_mux.sv - combinational 2:1 memory bus selector between loader and CPU
module mu0_bus_mux
    import mu0_pkg::*;
(
    input  logic              sel,
    input  logic              ldr_rd,
    input  logic              ldr_wr,
    input  logic [ADDR_W-1:0] ldr_address,
    input  logic [DATA_W-1:0] ldr_data,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data
);

    // sel=1 hands the bus to the CPU with zero added latency; otherwise the loader owns it.
    always_comb begin
        mem_rd      = ldr_rd;
        mem_wr      = ldr_wr;
        mem_address = ldr_address;
        mem_data    = ldr_data;
        if (sel) begin
            mem_rd      = cpu_rd;
            mem_wr      = cpu_wr;
            mem_address = cpu_address;
            mem_data    = cpu_data;
        end
    end

endmodule

// File: rtl/mu0_boot_loader.sv
// rtl/mu0_boot_loader.sv - byte-stream program loader that fills mu0 memory then releases the core
module mu0_boot_loader
    import mu0_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic [7:0]        Byte_in,
    input  logic              Byte_valid,
    output logic              Byte_ready,
    input  logic              Cpu_Rd,
    input  logic              Cpu_Wr,
    input  logic [ADDR_W-1:0] Cpu_Address,
    input  logic [DATA_W-1:0] Cpu_Data_out,
    output logic              Mem_Rd,
    output logic              Mem_Wr,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_Data,
    output logic              Cpu_Reset,
    output logic              Done,
    output logic              Error
);

    ldr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [7:0]        data_hi_q, data_hi_d;
    logic [7:0]        csum_q, csum_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              byte_fire;
    logic [15:0]       len_word;

    // Ready only in the byte-consuming states, and never while Reset is asserted.
    always_comb begin
        Byte_ready = 1'b0;
        if (!Reset) begin
            case (state_q)
                LEN_H, LEN_L, DATA_H, DATA_L, CHK: Byte_ready = 1'b1;
                default:                           Byte_ready = 1'b0;
            endcase
        end
    end

    assign byte_fire = Byte_valid && Byte_ready;
    assign len_word  = {len_hi_q, Byte_in};

    // Next-state and datapath: everything advances only on an accepted byte.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        len_hi_d   = len_hi_q;
        data_hi_d  = data_hi_q;
        csum_d     = csum_q;
        mem_wr_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        if (byte_fire) begin
            // The checksum byte itself is compared, not folded in.
            if (state_q != CHK) begin
                csum_d = csum_q ^ Byte_in;
            end
            case (state_q)
                LEN_H: begin
                    len_hi_d = Byte_in;
                    state_d  = LEN_L;
                end
                LEN_L: begin
                    if (len_word == 16'd0 || len_word > MAX_LEN) begin
                        state_d = ERR;
                    end else begin
                        count_d = len_word[CNT_W-1:0];
                        state_d = DATA_H;
                    end
                end
                DATA_H: begin
                    data_hi_d = Byte_in;
                    state_d   = DATA_L;
                end
                DATA_L: begin
                    mem_data_d = {data_hi_q, Byte_in};
                    mem_addr_d = addr_q;
                    mem_wr_d   = 1'b1;
                    // Wraps only after the final word at MAX_WORDS-1, when it is no longer used.
                    addr_d     = addr_q + ADDR_W'(1);
                    count_d    = count_q - CNT_W'(1);
                    state_d    = (count_q == CNT_W'(1)) ? CHK : DATA_H;
                end
                CHK: begin
                    state_d = (Byte_in == csum_q) ? RUN : ERR;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        // Status outputs are registered copies of where the FSM is heading.
        cpu_reset_d = (state_d != RUN);
        done_d      = (state_d == RUN);
        error_d     = (state_d == ERR);
    end

    // State and datapath registers with synchronous reset; memory contents are not touched.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= LEN_H;
            addr_q      <= '0;
            count_q     <= '0;
            len_hi_q    <= '0;
            data_hi_q   <= '0;
            csum_q      <= '0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            len_hi_q    <= len_hi_d;
            data_hi_q   <= data_hi_d;
            csum_q      <= csum_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign Cpu_Reset = cpu_reset_q;
    assign Done      = done_q;
    assign Error     = error_q;

    mu0_bus_mux u_bus_mux (
        .sel         (state_q == RUN),
        .ldr_rd      (1'b0),
        .ldr_wr      (mem_wr_q),
        .ldr_address (mem_addr_q),
        .ldr_data    (mem_data_q),
        .cpu_rd      (Cpu_Rd),
        .cpu_wr      (Cpu_Wr),
        .cpu_address (Cpu_Address),
        .cpu_data    (Cpu_Data_out),
        .mem_rd      (Mem_Rd),
        .mem_wr      (Mem_Wr),
        .mem_address (Mem_Address),
        .mem_data    (Mem_Data)
    );

endmodule

// File: tb/tb_mu0_boot_loader.sv
// tb/tb_mu0_boot_loader.sv - directed self-checking bench for mu0_boot_loader
module tb_mu0_boot_loader;

    logic        Clk;
    logic        Reset;
    logic [7:0]  Byte_in;
    logic        Byte_valid;
    logic        Byte_ready;
    logic        Cpu_Rd;
    logic        Cpu_Wr;
    logic [11:0] Cpu_Address;
    logic [15:0] Cpu_Data_out;
    logic        Mem_Rd;
    logic        Mem_Wr;
    logic [11:0] Mem_Address;
    logic [15:0] Mem_Data;
    logic        Cpu_Reset;
    logic        Done;
    logic        Error;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  img[$];
    logic [27:0] wr_log[$];
    logic [27:0] exp_wr[$];

    mu0_boot_loader dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Byte_in      (Byte_in),
        .Byte_valid   (Byte_valid),
        .Byte_ready   (Byte_ready),
        .Cpu_Rd       (Cpu_Rd),
        .Cpu_Wr       (Cpu_Wr),
        .Cpu_Address  (Cpu_Address),
        .Cpu_Data_out (Cpu_Data_out),
        .Mem_Rd       (Mem_Rd),
        .Mem_Wr       (Mem_Wr),
        .Mem_Address  (Mem_Address),
        .Mem_Data     (Mem_Data),
        .Cpu_Reset    (Cpu_Reset),
        .Done         (Done),
        .Error        (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Log every loader-driven write, sampled mid-cycle.
    always @(negedge Clk) begin
        if (Mem_Wr && !Done) wr_log.push_back({Mem_Address, Mem_Data});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset      = 1'b1;
        Byte_valid = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waits;
        @(negedge Clk);
        Byte_in    = b;
        Byte_valid = 1'b1;
        #1;
        waits = 0;
        while (!Byte_ready && waits < 20) begin
            @(negedge Clk);
            #1;
            waits++;
        end
        if (waits >= 20) begin
            check_eq("ready_timeout", 32'd0, 32'd1);
            Byte_valid = 1'b0;
        end else begin
            @(posedge Clk);
            #1;
            Byte_valid = 1'b0;
        end
    endtask

    task automatic send_img(input int gap);
        for (int i = 0; i < img.size(); i++) begin
            if (i > 0) repeat (gap) @(posedge Clk);
            send_byte(img[i]);
        end
    endtask

    task automatic check_writes(input string tag);
        check_eq({tag, "_count"}, wr_log.size(), exp_wr.size());
        if (wr_log.size() == exp_wr.size()) begin
            for (int i = 0; i < exp_wr.size(); i++) begin
                check_eq({tag, "_write"}, {4'h0, wr_log[i]}, {4'h0, exp_wr[i]});
            end
        end
        wr_log.delete();
    endtask

    task automatic check_status(input string tag, input logic done, input logic cpu_rst,
                                input logic err, input logic rdy);
        check_eq({tag, "_done"}, Done, done);
        check_eq({tag, "_cpu_reset"}, Cpu_Reset, cpu_rst);
        check_eq({tag, "_error"}, Error, err);
        check_eq({tag, "_ready"}, Byte_ready, rdy);
    endtask

    task automatic good_image();
        img    = '{8'h00, 8'h03, 8'h10, 8'h05, 8'h20, 8'h06, 8'h70, 8'h00, 8'h40};
        exp_wr = '{{12'h000, 16'h1005}, {12'h001, 16'h2006}, {12'h002, 16'h7000}};
    endtask

    initial begin
        logic [7:0]  cs;
        logic [15:0] w;

        Reset        = 1'b1;
        Byte_in      = 8'h00;
        Byte_valid   = 1'b0;
        Cpu_Rd       = 1'b0;
        Cpu_Wr       = 1'b0;
        Cpu_Address  = 12'h000;
        Cpu_Data_out = 16'h0000;

        // Reset state
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_eq("ready_in_reset", Byte_ready, 1'b0);
        Reset = 1'b0;
        #1;
        check_status("reset", 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("reset_mem_wr", Mem_Wr, 1'b0);
        check_eq("reset_mem_rd", Mem_Rd, 1'b0);

        // Good image back to back
        good_image();
        send_img(0);
        @(negedge Clk);
        check_status("good", 1'b1, 1'b0, 1'b0, 1'b0);
        check_writes("good");
        Cpu_Rd = 1'b1; Cpu_Wr = 1'b1; Cpu_Address = 12'h5A3; Cpu_Data_out = 16'hBEEF;
        #1;
        check_eq("run_mem_wr", Mem_Wr, 1'b1);
        check_eq("run_mem_rd", Mem_Rd, 1'b1);
        check_eq("run_mem_addr", Mem_Address, 12'h5A3);
        check_eq("run_mem_data", Mem_Data, 16'hBEEF);
        Cpu_Wr = 1'b0; Cpu_Address = 12'h00C;
        #1;
        check_eq("run_mem_wr_low", Mem_Wr, 1'b0);
        check_eq("run_mem_addr2", Mem_Address, 12'h00C);
        Cpu_Rd = 1'b0;

        // Reset after RUN
        do_reset();
        check_status("reset_after_run", 1'b0, 1'b1, 1'b0, 1'b1);

        // Bad checksum
        good_image();
        img[8] = 8'h41;
        send_img(0);
        @(negedge Clk);
        check_status("badcs", 1'b0, 1'b1, 1'b1, 1'b0);
        check_writes("badcs");
        Cpu_Wr = 1'b1; Cpu_Rd = 1'b1; Cpu_Address = 12'h777;
        #1;
        check_eq("err_mem_wr", Mem_Wr, 1'b0);
        check_eq("err_mem_rd", Mem_Rd, 1'b0);
        check_eq("err_mem_addr", Mem_Address, 12'h002);
        Cpu_Wr = 1'b0; Cpu_Rd = 1'b0; Cpu_Address = 12'h000;

        // Illegal length zero
        do_reset();
        img = '{8'h00, 8'h00};
        exp_wr.delete();
        send_img(0);
        @(negedge Clk);
        check_status("len0", 1'b0, 1'b1, 1'b1, 1'b0);
        check_writes("len0");

        // Illegal length 4097
        do_reset();
        img = '{8'h10, 8'h01};
        send_img(0);
        @(negedge Clk);
        check_status("len4097", 1'b0, 1'b1, 1'b1, 1'b0);
        check_writes("len4097");

        // Length 4096 accepted: full memory image, last write at 0xFFF
        do_reset();
        img = '{8'h10, 8'h00};
        cs  = 8'h10;
        exp_wr.delete();
        for (int i = 0; i < 4096; i++) begin
            w = 16'(i) ^ 16'hA5C3;
            img.push_back(w[15:8]);
            img.push_back(w[7:0]);
            cs = cs ^ w[15:8] ^ w[7:0];
            exp_wr.push_back({12'(i), w});
        end
        send_byte(img[0]);
        send_byte(img[1]);
        @(negedge Clk);
        check_status("len4096_hold", 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 2; i < img.size(); i++) send_byte(img[i]);
        @(negedge Clk);
        check_eq("len4096_before_chk_done", Done, 1'b0);
        send_byte(cs);
        @(negedge Clk);
        check_status("len4096", 1'b0 | 1'b1, 1'b0, 1'b0, 1'b0);
        check_writes("len4096");

        // Good image with 3-cycle valid gaps
        do_reset();
        good_image();
        send_img(3);
        @(negedge Clk);
        check_status("gaps", 1'b1, 1'b0, 1'b0, 1'b0);
        check_writes("gaps");

        // Reset mid-load after byte 0x20
        do_reset();
        good_image();
        for (int i = 0; i < 5; i++) send_byte(img[i]);
        do_reset();
        check_status("midreset", 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("midreset_mem_wr", Mem_Wr, 1'b0);
        check_eq("midreset_partial_writes", wr_log.size(), 1);
        wr_log.delete();
        send_img(0);
        @(negedge Clk);
        check_status("reload", 1'b1, 1'b0, 1'b0, 1'b0);
        check_writes("reload");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
